bp_tracker: RTL and testbench

BP_TRACKER -- requirements
Module: bp_tracker

---
 rtl/bp_tracker_pkg.sv | 16 +
 rtl/bp_tracker_fifo.sv | 75 +++++++
 rtl/bp_tracker.sv | 108 ++++++++++
 tb/tb_bp_tracker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_tracker_pkg.sv
// Shared branch-predictor definitions: boolean constants, default sizes and
// a saturating counter helper.
package bp_tracker_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DEFAULT_DEPTH = 16;
  localparam int unsigned DEFAULT_TAG_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bp_tracker_fifo.sv
// In-order storage of {tag, pred} for in-flight branches. Push and pop must
// arrive already qualified (push only when not full, pop only when not empty).
module bp_tracker_fifo
  import bp_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     wr_pred,
  output logic [TAG_W-1:0]         head_tag,
  output logic                     head_pred,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [TAG_W:0]    mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  // Pointer and occupancy next state; flush wins over any same-cycle push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (rdy) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (rdy && push && !flush) begin
      mem_q[wr_ptr_q] <= {wr_tag, wr_pred};
    end
  end

  assign head_tag  = mem_q[rd_ptr_q][TAG_W:1];
  assign head_pred = mem_q[rd_ptr_q][0];
  assign count     = count_q;
  assign full      = (count_q == (PtrW+1)'(DEPTH));

endmodule

// File: rtl/bp_tracker.sv
// Branch prediction tracker: queues issued predictions and, as branches
// commit in order, emits a predictor update plus a mispredict pulse.
// Optional macro BP_STAT_EN adds saturating commit/mispredict counters.
module bp_tracker
  import bp_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned TAG_W = DEFAULT_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             in_fetch_valid,
  input  logic [TAG_W-1:0] in_fetch_tag,
  input  logic             in_fetch_pred,
  output logic             out_fetch_full,
  input  logic             in_rob_valid,
  input  logic             in_rob_jump_res,
  input  logic             in_flush,
  output logic             out_bp_res,
  output logic [TAG_W-1:0] out_bp_tag,
  output logic             out_bp_jump_res,
`ifdef BP_STAT_EN
  output logic [31:0]      out_stat_total,
  output logic [31:0]      out_stat_miss,
`endif
  output logic             out_mispredict
);

  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic [TAG_W-1:0]       head_tag;
  logic                   head_pred;
  logic                   push_ok, pop_ok, miss;

  logic                   bp_res_q;
  logic [TAG_W-1:0]       bp_tag_q;
  logic                   bp_jump_res_q;
  logic                   mispredict_q;

  // Push gated by the registered full flag; a same-cycle flush discards it.
  assign push_ok = in_fetch_valid && !full && !in_flush;
  assign pop_ok  = in_rob_valid && (count != '0);
  assign miss    = pop_ok && (head_pred != in_rob_jump_res);

  bp_tracker_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .push      (push_ok),
    .pop       (pop_ok),
    .flush     (in_flush),
    .wr_tag    (in_fetch_tag),
    .wr_pred   (in_fetch_pred),
    .head_tag  (head_tag),
    .head_pred (head_pred),
    .count     (count),
    .full      (full)
  );

  // Predictor update registers; pulses last one cycle per accepted pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bp_res_q      <= FALSE;
      bp_tag_q      <= '0;
      bp_jump_res_q <= FALSE;
      mispredict_q  <= FALSE;
    end else if (rdy) begin
      bp_res_q     <= pop_ok;
      mispredict_q <= miss;
      if (pop_ok) begin
        bp_tag_q      <= head_tag;
        bp_jump_res_q <= in_rob_jump_res;
      end
    end else begin
      bp_res_q     <= FALSE;
      mispredict_q <= FALSE;
    end
  end

`ifdef BP_STAT_EN
  logic [31:0] stat_total_q, stat_miss_q;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else if (rdy && pop_ok) begin
      stat_total_q <= sat_inc(stat_total_q);
      if (miss) stat_miss_q <= sat_inc(stat_miss_q);
    end
  end

  assign out_stat_total = stat_total_q;
  assign out_stat_miss  = stat_miss_q;
`endif

  assign out_fetch_full  = full;
  assign out_bp_res      = bp_res_q;
  assign out_bp_tag      = bp_tag_q;
  assign out_bp_jump_res = bp_jump_res_q;
  assign out_mispredict  = mispredict_q;

endmodule

// File: tb/tb_bp_tracker.sv
// Directed bench for bp_tracker: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/drain, reset and statistics.
module tb_bp_tracker;

  logic       clk = 1'b0;
  logic       rst, rdy, in_fetch_valid, in_fetch_pred, in_rob_valid;
  logic       in_rob_jump_res, in_flush;
  logic [7:0] in_fetch_tag;
  logic       out_fetch_full, out_bp_res, out_bp_jump_res, out_mispredict;
  logic [7:0] out_bp_tag;
`ifdef BP_STAT_EN
  logic [31:0] out_stat_total, out_stat_miss;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .in_fetch_valid  (in_fetch_valid),
    .in_fetch_tag    (in_fetch_tag),
    .in_fetch_pred   (in_fetch_pred),
    .out_fetch_full  (out_fetch_full),
    .in_rob_valid    (in_rob_valid),
    .in_rob_jump_res (in_rob_jump_res),
    .in_flush        (in_flush),
    .out_bp_res      (out_bp_res),
    .out_bp_tag      (out_bp_tag),
    .out_bp_jump_res (out_bp_jump_res),
`ifdef BP_STAT_EN
    .out_stat_total  (out_stat_total),
    .out_stat_miss   (out_stat_miss),
`endif
    .out_mispredict  (out_mispredict)
  );

  typedef struct {
    logic       rdy;
    logic       fv;
    logic [7:0] ftag;
    logic       fpred;
    logic       rv;
    logic       rres;
    logic       flush;
    logic       e_full;
    logic       e_res;
    logic [7:0] e_tag;
    logic       e_jres;
    logic       e_mis;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [7:0] ftag, input logic fpred,
                       input logic rv, input logic rres, input logic fl);
    rdy             = r;
    in_fetch_valid  = fv;
    in_fetch_tag    = ftag;
    in_fetch_pred   = fpred;
    in_rob_valid    = rv;
    in_rob_jump_res = rres;
    in_flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Commit the head with the given outcome and check the update one cycle later.
  task automatic commit_chk(input string name, input logic res, input logic [7:0] e_tag,
                            input logic e_mis);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, res, 1'b0);
    tick();
    chk({name, " res"}, 32'(out_bp_res), 32'd1);
    chk({name, " tag"}, 32'(out_bp_tag), 32'(e_tag));
    chk({name, " jres"}, 32'(out_bp_jump_res), 32'(res));
    chk({name, " mis"}, 32'(out_mispredict), 32'(e_mis));
  endtask

  task automatic push(input logic [7:0] tag, input logic pred);
    drive(1'b1, 1'b1, tag, pred, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  logic [7:0] exp_tags [16];

  initial begin
    //           rdy   fv    ftag   fpr   rv    rres  flush full  res   tag    jres  mis
    vecs[0]  = '{1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 10; i < 15; i++)
      vecs[i] = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    // Reset state
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset full", 32'(out_fetch_full), 32'd0);
    chk("reset res", 32'(out_bp_res), 32'd0);
    chk("reset tag", 32'(out_bp_tag), 32'd0);
    chk("reset jres", 32'(out_bp_jump_res), 32'd0);
    chk("reset mis", 32'(out_mispredict), 32'd0);
    rst = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rdy, vecs[i].fv, vecs[i].ftag, vecs[i].fpred, vecs[i].rv, vecs[i].rres,
            vecs[i].flush);
      tick();
      chk($sformatf("vec%0d full", i), 32'(out_fetch_full), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d res", i), 32'(out_bp_res), 32'(vecs[i].e_res));
      chk($sformatf("vec%0d mis", i), 32'(out_mispredict), 32'(vecs[i].e_mis));
      if (vecs[i].e_res) begin
        chk($sformatf("vec%0d tag", i), 32'(out_bp_tag), 32'(vecs[i].e_tag));
        chk($sformatf("vec%0d jres", i), 32'(out_bp_jump_res), 32'(vecs[i].e_jres));
      end
    end

    // Fill to 16, drop a 17th push, drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h10 + i), 1'(i % 2));
      chk($sformatf("fill%0d full", i), 32'(out_fetch_full), (i == 15) ? 32'd1 : 32'd0);
    end
    push(8'hFF, 1'b1);
    chk("drop17 full", 32'(out_fetch_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      commit_chk($sformatf("drain%0d", i), 1'b0, 8'(8'h10 + i), 1'(i % 2));
      chk($sformatf("drain%0d full", i), 32'(out_fetch_full), 32'd0);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("empty commit res", 32'(out_bp_res), 32'd0);

    // Simultaneous push/pop at full (push dropped) and at 15 (both performed)
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0);
    chk("refill full", 32'(out_fetch_full), 32'd1);
    drive(1'b1, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fullpp res", 32'(out_bp_res), 32'd1);
    chk("fullpp tag", 32'(out_bp_tag), 32'h20);
    chk("fullpp mis", 32'(out_mispredict), 32'd1);
    chk("fullpp full", 32'(out_fetch_full), 32'd0);
    drive(1'b1, 1'b1, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("c15pp tag", 32'(out_bp_tag), 32'h21);
    chk("c15pp full", 32'(out_fetch_full), 32'd0);
    push(8'hFC, 1'b0);
    chk("c15pp count16", 32'(out_fetch_full), 32'd1);
    for (int i = 0; i < 14; i++) exp_tags[i] = 8'(8'h22 + i);
    exp_tags[14] = 8'hFD;
    exp_tags[15] = 8'hFC;
    for (int i = 0; i < 16; i++) commit_chk($sformatf("drain2_%0d", i), 1'b0, exp_tags[i], 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("drain2 empty res", 32'(out_bp_res), 32'd0);

    // Reset mid-stream beats a same-cycle commit and drops entries
    push(8'h44, 1'b1);
    push(8'h55, 1'b1);
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    chk("midrst res", 32'(out_bp_res), 32'd0);
    chk("midrst tag", 32'(out_bp_tag), 32'd0);
    chk("midrst jres", 32'(out_bp_jump_res), 32'd0);
    chk("midrst mis", 32'(out_mispredict), 32'd0);
    chk("midrst full", 32'(out_fetch_full), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("midrst dropped", 32'(out_bp_res), 32'd0);

`ifdef BP_STAT_EN
    // Four commits, one mispredicted; a flush must not clear the counters
    for (int i = 0; i < 4; i++) push(8'(i + 1), 1'b0);
    commit_chk("stat0", 1'b0, 8'h01, 1'b0);
    commit_chk("stat1", 1'b0, 8'h02, 1'b0);
    commit_chk("stat2", 1'b1, 8'h03, 1'b1);
    commit_chk("stat3", 1'b0, 8'h04, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stat total", out_stat_total, 32'd4);
    chk("stat miss", out_stat_miss, 32'd1);
`endif

    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
